frame_bram_pp: RTL and testbench

Parametrised, double-buffered (ping-pong) frame store for the scaling pipeline. A raster writer fills one bank with a full frame at one pixel per cycle while the scaler randomly reads the other bank with 1-cycle latency. At end of scale, the block appends a programmable zero-pixel flush tail and raises `finish`. Banks swap under handshake, so capture of frame N+1 overlaps scaling of frame N.

---
 rtl/frame_bram_pkg.sv | 22 ++
 rtl/frame_bram_pp_bram_sdp.sv | 29 ++
 rtl/frame_bram_pp.sv | 162 ++++++++++++++++
 tb/tb_frame_bram_pp.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_bram_pkg.sv
// Shared types and defaults for the ping-pong frame store.
package frame_bram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } flush_state_t;

  localparam int DEF_IMG_W     = 640;
  localparam int DEF_IMG_H     = 480;
  localparam int DEF_FLUSH_LEN = 20;

  // Smallest address width that can reach every word of a bank.
  function automatic int addr_w_for(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/frame_bram_pp_bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module bram_sdp #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read register only loads on re, so the last read word is held.
  always_ff @(posedge clk) begin
    if (we) mem[waddr[IDX_W-1:0]] <= wdata;
    if (re) rdata_q <= mem[raddr[IDX_W-1:0]];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_bram_pp.sv
// Double-buffered frame store: raster writes fill one bank while the scaler
// reads the other; a zero-pixel flush tail follows end_scale.
module frame_bram_pp
  import frame_bram_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int DEPTH     = IMG_W * IMG_H,
  parameter int ADDR_W    = addr_w_for(DEPTH),
  parameter int FLUSH_LEN = DEF_FLUSH_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] write_addr,
  output logic              overflow,
  output logic              frame_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              end_scale,
  input  logic              rd_release,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              finish
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        FLUSH_END = 8'(FLUSH_LEN);

  flush_state_t      state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [7:0]        flush_cnt_q, flush_cnt_d;
  logic              overflow_q, overflow_d;
  logic              data_valid_q, data_valid_d;
  logic              out_zero_q, out_zero_d;
  logic              out_bank_q, out_bank_d;

  logic              wr_fire, rd_fire, release_ok, frame_ready_w;
  logic [DATA_W-1:0] bank_rdata [2];

  always_comb begin
    frame_ready_w = bank_full_q[rd_bank_q];
    wr_fire       = wr_en && !bank_full_q[wr_bank_q];
    rd_fire       = rd_en && frame_ready_w && !end_scale;
    release_ok    = rd_release && frame_ready_w;

    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    bank_full_d  = bank_full_q;
    write_addr_d = write_addr_q;
    flush_cnt_d  = flush_cnt_q;
    overflow_d   = overflow_q;
    data_valid_d = 1'b0;
    out_zero_d   = out_zero_q;
    out_bank_d   = out_bank_q;

    if (wr_en && bank_full_q[wr_bank_q]) overflow_d = 1'b1;

    if (wr_fire) begin
      if (write_addr_q == LAST_ADDR) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        write_addr_d           = '0;
      end else begin
        write_addr_d = write_addr_q + 1'b1;
      end
    end

    // end_scale and rd_fire are mutually exclusive, so no priority is needed.
    if (rd_fire) begin
      data_valid_d = 1'b1;
      out_zero_d   = 1'b0;
      out_bank_d   = rd_bank_q;
    end

    if (release_ok) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
      flush_cnt_d            = '0;
      state_d                = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (end_scale && frame_ready_w) begin
            state_d      = FLUSH;
            flush_cnt_d  = flush_cnt_q + 1'b1;
            data_valid_d = 1'b1;
            out_zero_d   = 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == FLUSH_END) begin
            state_d = DONE;
          end else if (end_scale) begin
            flush_cnt_d  = flush_cnt_q + 1'b1;
            data_valid_d = 1'b1;
            out_zero_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      bank_full_q  <= 2'b00;
      write_addr_q <= '0;
      flush_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      data_valid_q <= 1'b0;
      out_zero_q   <= 1'b1;
      out_bank_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      bank_full_q  <= bank_full_d;
      write_addr_q <= write_addr_d;
      flush_cnt_q  <= flush_cnt_d;
      overflow_q   <= overflow_d;
      data_valid_q <= data_valid_d;
      out_zero_q   <= out_zero_d;
      out_bank_q   <= out_bank_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    bram_sdp #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk  (clk),
      .we   (wr_fire && (wr_bank_q == 1'(gi))),
      .waddr(write_addr_q),
      .wdata(data_in),
      .re   (rd_fire && (rd_bank_q == 1'(gi))),
      .raddr(rd_addr),
      .rdata(bank_rdata[gi])
    );
  end

  assign wr_ready    = !bank_full_q[wr_bank_q];
  assign write_addr  = write_addr_q;
  assign overflow    = overflow_q;
  assign frame_ready = frame_ready_w;
  assign data_valid  = data_valid_q;
  assign data_out    = out_zero_q ? '0 : bank_rdata[out_bank_q];
  assign finish      = (state_q == DONE);

endmodule

// File: tb/tb_frame_bram_pp.sv
// Randomised self-checking bench for frame_bram_pp using a pixel-queue model.
module tb_frame_bram_pp;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int IH = 4;
  localparam int D  = IW * IH;
  localparam int AW = 5;
  localparam int FL = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wr_ready;
  logic [AW-1:0] write_addr;
  logic          overflow;
  logic          frame_ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          end_scale = 1'b0;
  logic          rd_release = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          finish;

  always #5 clk = ~clk;

  frame_bram_pp #(
    .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .DEPTH(D), .ADDR_W(AW), .FLUSH_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .wr_ready(wr_ready),
    .write_addr(write_addr), .overflow(overflow), .frame_ready(frame_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .end_scale(end_scale), .rd_release(rd_release),
    .data_out(data_out), .data_valid(data_valid), .finish(finish)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Model: completed frames in arrival order (front frame = readable one),
  // plus the frame currently being captured.
  logic [DW-1:0] pix_q[$];
  logic [DW-1:0] cur_q[$];
  bit            ovf_m = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input bit we, input logic [DW-1:0] din, input bit rel);
    bit accept, do_rel;
    accept = we && (pix_q.size() < 2 * D);
    do_rel = rel && (pix_q.size() >= D);
    wr_en = we; data_in = din; rd_release = rel;
    tick();
    wr_en = 1'b0; rd_release = 1'b0;
    if (we && !accept) ovf_m = 1'b1;
    if (do_rel) repeat (D) void'(pix_q.pop_front());
    if (accept) begin
      cur_q.push_back(din);
      if (cur_q.size() == D) begin
        foreach (cur_q[i]) pix_q.push_back(cur_q[i]);
        cur_q.delete();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    pix_q.delete(); cur_q.delete(); ovf_m = 1'b0;
    tests_run++;
    if ({wr_ready, frame_ready, finish, data_valid, overflow} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_flags: got rdy/frm/fin/val/ovf=%b want 10000",
               {wr_ready, frame_ready, finish, data_valid, overflow});
    end
    tests_run++;
    if (write_addr !== '0 || data_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_regs: got write_addr=%0d data_out=%0h want 0/0", write_addr, data_out);
    end
    rd_en = 1'b1; rd_addr = AW'($urandom_range(0, D - 1));
    tick();
    rd_en = 1'b0;
    tests_run++;
    if (data_valid !== 1'b0 || data_out !== '0) begin
      tests_failed++;
      $display("FAIL read_no_frame: got valid=%b data=%0h want 0/0", data_valid, data_out);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_fill(input bit rel_on_last);
    tests_run++;
    if (wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_ready: got wr_ready=%b want 1", wr_ready);
    end
    for (int i = 0; i < D; i++) begin
      tests_run++;
      if (write_addr !== AW'(cur_q.size())) begin
        tests_failed++;
        $display("FAIL fill_addr: got write_addr=%0d want %0d", write_addr, cur_q.size());
      end
      drive_write(1'b1, DW'($urandom), rel_on_last && (i == D - 1));
    end
    tests_run++;
    if (frame_ready !== (pix_q.size() >= D) || wr_ready !== (pix_q.size() < 2 * D)
        || write_addr !== '0) begin
      tests_failed++;
      $display("FAIL fill_done: got frm=%b rdy=%b addr=%0d want %b %b 0",
               frame_ready, wr_ready, write_addr, pix_q.size() >= D, pix_q.size() < 2 * D);
    end
    $display("[TB] frame filled (release_on_last=%0b), frames held=%0d", rel_on_last, pix_q.size() / D);
  endtask

  task automatic test_reads(input int n);
    int a;
    logic [DW-1:0] last;
    last = '0;
    for (int k = 0; k < n; k++) begin
      if (k == 0) a = 0;
      else if (k == 1) a = 1;
      else if (k == 2) a = D - 1;
      else a = $urandom_range(0, D - 1);
      rd_en = 1'b1; rd_addr = AW'(a);
      tick();
      last = pix_q[a];
      tests_run++;
      if (data_valid !== 1'b1 || data_out !== last) begin
        tests_failed++;
        $display("FAIL read_addr%0d: got valid=%b data=%0h want 1/%0h", a, data_valid, data_out, last);
      end
    end
    rd_en = 1'b0;
    tick();
    tests_run++;
    if (data_valid !== 1'b0 || data_out !== last) begin
      tests_failed++;
      $display("FAIL read_hold: got valid=%b data=%0h want 0/%0h", data_valid, data_out, last);
    end
    $display("[TB] %0d back-to-back reads checked", n);
  endtask

  task automatic test_flush();
    int  cnt;
    bit  got_finish;
    cnt = 0; got_finish = 1'b0;
    end_scale = 1'b1; rd_en = 1'b1; rd_addr = AW'($urandom_range(0, D - 1));
    for (int c = 0; c < 100 && !got_finish; c++) begin
      tick();
      if (finish === 1'b1) got_finish = 1'b1;
      else if (data_valid === 1'b1) begin
        cnt++;
        tests_run++;
        if (data_out !== '0) begin
          tests_failed++;
          $display("FAIL flush_zero: got data_out=%0h want 0", data_out);
        end
      end
    end
    tests_run++;
    if (!got_finish || cnt != FL) begin
      tests_failed++;
      $display("FAIL flush_len: got finish=%b zeros=%0d want 1/%0d", got_finish, cnt, FL);
    end
    repeat (3) begin
      tick();
      tests_run++;
      if (finish !== 1'b1 || data_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_done: got finish=%b valid=%b want 1/0", finish, data_valid);
      end
    end
    end_scale = 1'b0; rd_en = 1'b0;
    tick();
    tests_run++;
    if (finish !== 1'b1) begin
      tests_failed++;
      $display("FAIL finish_level: got finish=%b want 1", finish);
    end
    $display("[TB] flush tail of %0d zeros checked", cnt);
  endtask

  task automatic test_overflow();
    test_fill(1'b0);
    repeat (4) begin
      drive_write(1'b1, DW'($urandom), 1'b0);
      tests_run++;
      if (overflow !== ovf_m || wr_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL overflow: got ovf=%b rdy=%b want %b/0", overflow, wr_ready, ovf_m);
      end
    end
    drive_write(1'b0, '0, 1'b1);
    tests_run++;
    if (wr_ready !== 1'b1 || frame_ready !== 1'b1 || finish !== 1'b0) begin
      tests_failed++;
      $display("FAIL release: got rdy=%b frm=%b fin=%b want 1/1/0", wr_ready, frame_ready, finish);
    end
    $display("[TB] overflow and release checked");
    test_reads(8);
  endtask

  task automatic test_back_to_back();
    test_fill(1'b1);
    tests_run++;
    if (overflow !== ovf_m) begin
      tests_failed++;
      $display("FAIL overflow_sticky: got %b want %b", overflow, ovf_m);
    end
    test_reads(8);
  endtask

  task automatic test_reset_mid_flush();
    end_scale = 1'b1;
    repeat (5) drive_write(1'b1, DW'($urandom), 1'b0);
    tests_run++;
    if (data_valid !== 1'b1 || data_out !== '0) begin
      tests_failed++;
      $display("FAIL mid_flush: got valid=%b data=%0h want 1/0", data_valid, data_out);
    end
    end_scale = 1'b0;
    test_reset();
    test_fill(1'b0);
    test_reads(6);
    test_flush();
    drive_write(1'b0, '0, 1'b1);
    tests_run++;
    if (frame_ready !== 1'b0 || finish !== 1'b0 || wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL final_release: got frm=%b fin=%b rdy=%b want 0/0/1", frame_ready, finish, wr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_fill(1'b0);
    test_reads(10);
    test_flush();
    test_overflow();
    test_back_to_back();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
